// File: rtl/aidc_lite_decomp_sr.sv
// aidc_lite_decomp_sr: fetches NUM_WORDS 64-bit compressed words per packet and
// expands each 32-bit half into four sign-extended 16-bit lanes, two beats per word.
module aidc_lite_decomp_sr #(
    parameter int NUM_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        busy_o,
    output logic        rd_en_o,
    output logic [3:0]  rd_addr_o,
    input  logic [63:0] rd_data_i,
    output logic        valid_o,
    output logic        sop_o,
    output logic        eop_o,
    output logic [63:0] data_o,
    output logic        hdr_err_o
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HI, S_LO} state_t;

    localparam logic [3:0] LAST = 4'(NUM_WORDS - 1);

    state_t      r_state, w_next;
    logic        r_busy, r_rd_en, r_valid, r_sop, r_eop, r_hdr_err, r_first;
    logic [3:0]  r_addr;
    logic [63:0] r_hold, r_data;
    logic        w_busy, w_rd_en, w_valid, w_sop, w_eop, w_hdr_err, w_first;
    logic [3:0]  w_addr;
    logic        w_accept, w_more;
    logic [31:0] w_half;
    logic [63:0] w_beat;

    function automatic logic [15:0] sx8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    // The previous beat's eop marks the last busy cycle, so a start there is dropped.
    assign w_accept = (r_state == S_IDLE) && start_i && !r_busy;
    assign w_more   = (r_state == S_HI) && (r_addr != LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_FETCH : S_IDLE;
            S_FETCH: w_next = S_HI;
            S_HI:    w_next = S_LO;
            S_LO:    w_next = r_rd_en ? S_HI : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = w_accept ? 1'b1 : (r_eop ? 1'b0 : r_busy);
        w_rd_en   = w_accept || w_more;
        w_addr    = w_accept ? 4'd0 : (w_more ? r_addr + 4'd1 : r_addr);
        w_valid   = (r_state == S_HI) || (r_state == S_LO);
        w_sop     = (r_state == S_HI) && r_first;
        w_eop     = (r_state == S_LO) && !r_rd_en;
        w_first   = w_accept ? 1'b1 : ((r_state == S_HI) ? 1'b0 : r_first);
        w_hdr_err = ((r_state == S_HI) && r_first) ? ~rd_data_i[63] : r_hdr_err;
    end

    // High half comes straight off the read bus; low half waits in r_hold.
    always_comb begin
        w_half = (r_state == S_HI) ? rd_data_i[63:32] : r_hold[31:0];
        w_beat = {sx8(w_half[31:24]), sx8(w_half[23:16]), sx8(w_half[15:8]), sx8(w_half[7:0])};
        if ((r_state == S_HI) && r_first) w_beat[63:48] = {{9{w_half[30]}}, w_half[30:24]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= 4'd0;
            r_valid   <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_hdr_err <= 1'b0;
            r_first   <= 1'b0;
        end else begin
            r_busy    <= w_busy;
            r_rd_en   <= w_rd_en;
            r_addr    <= w_addr;
            r_valid   <= w_valid;
            r_sop     <= w_sop;
            r_eop     <= w_eop;
            r_hdr_err <= w_hdr_err;
            r_first   <= w_first;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_HI) r_hold <= rd_data_i;
        r_data <= w_beat;
    end

    assign busy_o    = r_busy;
    assign rd_en_o   = r_rd_en;
    assign rd_addr_o = r_addr;
    assign valid_o   = r_valid;
    assign sop_o     = r_sop;
    assign eop_o     = r_eop;
    assign data_o    = r_data;
    assign hdr_err_o = r_hdr_err;
endmodule

// File: doc/aidc_lite_decomp_sr.md
AIDC_LITE_DECOMP_SR -- requirements
Module: aidc_lite_decomp_sr

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 8, meaning compressed 64-bit words per packet (legal 1..16); output beats per packet = 2*NUM_WORDS.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start_i  input  1  one-cycle request to decompress one packet.
REQ-005 SHALL have port busy_o  output  1  packet in progress.
REQ-006 SHALL have port rd_en_o  output  1  read strobe to compressed-word buffer.
REQ-007 SHALL have port rd_addr_o  output  4  word address, valid when rd_en_o=1.
REQ-008 SHALL have port rd_data_i  input  64  read data, valid exactly one cycle after rd_en_o; no backpressure.
REQ-009 SHALL have port valid_o  output  1  output beat valid; no backpressure.
REQ-010 SHALL have port sop_o  output  1  first beat of packet.
REQ-011 SHALL have port eop_o  output  1  last beat of packet.
REQ-012 SHALL have port data_o  output  64  decompressed beat, four 16-bit lanes.
REQ-013 SHALL have port hdr_err_o  output  1  word-0 header bit was 0; meaningful on eop_o beat.

Function
REQ-014 SHALL use FSM S_IDLE, S_FETCH, S_HI, S_LO; S_IDLE -> S_FETCH on start_i; S_FETCH -> S_HI; S_HI -> S_LO; S_LO -> S_HI if words remain, else S_IDLE.
REQ-015 SHALL ignore start_i when busy_o=1.
REQ-016 SHALL, for start_i sampled at edge k: drive rd_en_o=1, rd_addr_o=0 in cycle k+1; busy_o=1 from cycle k+1 through last-beat cycle.
REQ-017 SHALL issue one read every 2 cycles (cycles k+1, k+3, ..., k+2*NUM_WORDS-1), rd_addr_o incrementing 0..NUM_WORDS-1; rd_en_o=0 otherwise.
REQ-018 SHALL register outputs; first beat valid in cycle k+3, then valid_o=1 continuously for 2*NUM_WORDS cycles (beat j from word j/2, even j = bits [63:32], odd j = bits [31:0]).
REQ-019 SHALL capture rd_data_i into a holding register so the low half is emitted after the next read's data arrives without loss.
REQ-020 SHALL expand each 32-bit half {b3,b2,b1,b0} (b3 most significant) to data_o = {sx(b3), sx(b2), sx(b1), sx(b0)}, sx = 8-bit to 16-bit sign extension.
REQ-021 SHALL, for beat 0 only, treat word0[63] as header, set lane3 = 7-bit-to-16-bit sign extension of word0[62:56], lanes 2..0 per REQ-020.
REQ-022 SHALL set hdr_err_o = ~word0[63] from cycle k+3, hold it until next packet's beat 0.
REQ-023 SHALL assert sop_o only with beat 0, eop_o only with beat 2*NUM_WORDS-1; NUM_WORDS=1 gives 2-beat packet with distinct sop and eop.
REQ-024 SHALL deassert busy_o cycle after eop_o; start_i in eop_o cycle ignored, accepted in the following cycle.
REQ-025 SHALL not wrap rd_addr_o past NUM_WORDS-1 within a packet; restart at 0 per packet.
REQ-026 SHALL leave data_o don't-care when valid_o=0.

Reset
REQ-027 SHALL, with rst_n=0 at an edge, force state S_IDLE, busy_o=0, rd_en_o=0, rd_addr_o=0, valid_o=0, sop_o=0, eop_o=0, hdr_err_o=0; data path registers not reset.
REQ-028 SHALL abort an in-progress packet on reset with no further beats or reads; next start_i after release behaves per REQ-016.

Verification
REQ-029 Bench SHALL cover: word0=0x810203FF_7F800001, start_i at k -> cycle k+3 data_o=0x0001_0002_0003_FFFF with sop_o=1, cycle k+4 data_o=0x007F_FF80_0000_0001, hdr_err_o=0.
REQ-030 Bench SHALL cover: word0[63:56]=0xC0 -> beat 0 lane3=0xFFC0; word0[63]=0 -> hdr_err_o=1 on eop_o.
REQ-031 Bench SHALL cover: NUM_WORDS=8 -> reads at k+1,k+3..k+15 addr 0..7; valid_o high k+3..k+18 unbroken; eop_o at k+18; busy_o low k+19.
REQ-032 Bench SHALL cover: start_i pulses during busy_o and in eop_o cycle -> ignored; start_i at k+19 -> new packet, sop_o at k+22.
REQ-033 Bench SHALL cover: rst_n=0 at k+6 mid-packet -> all control outputs 0 next cycle, no further rd_en_o/valid_o until new start_i.
REQ-034 Bench SHALL cover: round trip with compressor -> 16 sign-reducible beats compressed then decompressed reproduce input exactly.
